bram_port_arbiter: RTL and testbench

BRAM_PORT_ARBITER -- requirements
Module: bram_port_arbiter

---
 rtl/bram_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_bram_port_arbiter.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// bram_port_arbiter
// Arbitrates two request/response clients onto a true dual-port BRAM with a
// 1-cycle registered read. Client 0 owns port A and client 1 owns port B.
// Each client keeps up to two reads outstanding: one can be in flight and
// the rest sit in a 2-entry response FIFO. Two requests to the same address
// where at least one is a write are a conflict; a round-robin priority bit
// picks the winner and flips after each resolved conflict.
//
// Ports
//   CLK, RESET_N                 clock, async active-low reset
//   REQ_VALID_x/READY_x          client x request handshake (x = 0,1)
//   REQ_WE_x/ADDR_x/DATA_x       client x request payload
//   RESP_VALID_x/READY_x/DATA_x  client x read response handshake
//   ADDR_p/DI_p/WE_p             BRAM port p command (p = A,B)
//   DO_p                         BRAM port p registered read data
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module bram_port_arbiter #(
  parameter int unsigned ADDR_WIDTH = 1,
  parameter int unsigned DATA_WIDTH = 1
) (
  input  logic                  CLK,
  input  logic                  RESET_N,
  // client 0
  input  logic                  REQ_VALID_0,
  output logic                  REQ_READY_0,
  input  logic                  REQ_WE_0,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_0,
  input  logic [DATA_WIDTH-1:0] REQ_DATA_0,
  output logic                  RESP_VALID_0,
  input  logic                  RESP_READY_0,
  output logic [DATA_WIDTH-1:0] RESP_DATA_0,
  // client 1
  input  logic                  REQ_VALID_1,
  output logic                  REQ_READY_1,
  input  logic                  REQ_WE_1,
  input  logic [ADDR_WIDTH-1:0] REQ_ADDR_1,
  input  logic [DATA_WIDTH-1:0] REQ_DATA_1,
  output logic                  RESP_VALID_1,
  input  logic                  RESP_READY_1,
  output logic [DATA_WIDTH-1:0] RESP_DATA_1,
  // BRAM port A
  output logic [ADDR_WIDTH-1:0] ADDR_A,
  output logic [DATA_WIDTH-1:0] DI_A,
  output logic                  WE_A,
  input  logic [DATA_WIDTH-1:0] DO_A,
  // BRAM port B
  output logic [ADDR_WIDTH-1:0] ADDR_B,
  output logic [DATA_WIDTH-1:0] DI_B,
  output logic                  WE_B,
  input  logic [DATA_WIDTH-1:0] DO_B
);

  localparam int unsigned NUM_CLIENTS = 2;
  localparam int unsigned CNT_W       = 2;

  // Per-client views of the flat ports, indexed by client number.
  logic [NUM_CLIENTS-1:0]                 w_valid;
  logic [NUM_CLIENTS-1:0]                 w_we;
  logic [NUM_CLIENTS-1:0]                 w_resp_ready;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] w_do;
  logic [NUM_CLIENTS-1:0]                 w_resp_valid;
  logic [NUM_CLIENTS-1:0][DATA_WIDTH-1:0] w_resp_data;

  logic [NUM_CLIENTS-1:0] w_room;
  logic [NUM_CLIENTS-1:0] w_grant;
  logic [NUM_CLIENTS-1:0] w_ready;
  logic [NUM_CLIENTS-1:0] w_accept;
  logic                   w_conflict;

  logic r_prio;
  logic w_prio_nxt;

  assign w_valid      = {REQ_VALID_1, REQ_VALID_0};
  assign w_we         = {REQ_WE_1, REQ_WE_0};
  assign w_resp_ready = {RESP_READY_1, RESP_READY_0};
  assign w_do         = {DO_B, DO_A};

  // Same-address access with at least one write must be serialised.
  assign w_conflict = REQ_VALID_0 & REQ_VALID_1 & (REQ_ADDR_0 == REQ_ADDR_1) &
                      (REQ_WE_0 | REQ_WE_1);

  // Grant and accept: loser of a conflict is held off, reset blocks everyone.
  always_comb begin
    w_grant = {NUM_CLIENTS{1'b1}};
    if (w_conflict) begin
      w_grant = r_prio ? 2'b10 : 2'b01;
    end
    w_ready  = w_grant & w_room & {NUM_CLIENTS{RESET_N}};
    w_accept = w_ready & w_valid;
  end

  // Priority next-state: flip only when the conflict winner actually went.
  always_comb begin
    w_prio_nxt = r_prio;
    if (w_conflict && w_accept[r_prio]) begin
      w_prio_nxt = ~r_prio;
    end
  end

  // Priority register.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      r_prio <= 1'b0;
    end else begin
      r_prio <= w_prio_nxt;
    end
  end

  // Per-client in-flight flag and 2-entry response FIFO.
  for (genvar g = 0; g < NUM_CLIENTS; g++) begin : g_client
    logic                  r_inflight;
    logic [CNT_W-1:0]      r_count;
    logic                  r_wr_ptr;
    logic                  r_rd_ptr;
    logic [DATA_WIDTH-1:0] r_mem [2];
    logic                  w_push;
    logic                  w_pop;
    logic [CNT_W-1:0]      w_occ;

    assign w_push = r_inflight;
    assign w_pop  = (r_count != '0) & w_resp_ready[g];
    assign w_occ  = CNT_W'({1'b0, r_inflight}) + r_count;

    // Writes never wait; a read needs a free slot now or one freed by a pop.
    assign w_room[g] = w_we[g] | (w_occ < CNT_W'(2)) | w_pop;

    assign w_resp_valid[g] = (r_count != '0);
    assign w_resp_data[g]  = r_mem[r_rd_ptr];

    // Control state; reset drops reads in flight and empties the FIFO.
    always_ff @(posedge CLK or negedge RESET_N) begin
      if (!RESET_N) begin
        r_inflight <= 1'b0;
        r_count    <= '0;
        r_wr_ptr   <= 1'b0;
        r_rd_ptr   <= 1'b0;
      end else begin
        r_inflight <= w_accept[g] & ~w_we[g];
        r_count    <= CNT_W'(r_count + CNT_W'(w_push) - CNT_W'(w_pop));
        if (w_push) begin
          r_wr_ptr <= ~r_wr_ptr;
        end
        if (w_pop) begin
          r_rd_ptr <= ~r_rd_ptr;
        end
      end
    end

    // Storage captures BRAM read data the cycle after the read was issued.
    always_ff @(posedge CLK) begin
      if (w_push) begin
        r_mem[r_wr_ptr] <= w_do[g];
      end
    end
  end

  assign REQ_READY_0  = w_ready[0];
  assign REQ_READY_1  = w_ready[1];
  assign RESP_VALID_0 = w_resp_valid[0];
  assign RESP_VALID_1 = w_resp_valid[1];
  assign RESP_DATA_0  = w_resp_data[0];
  assign RESP_DATA_1  = w_resp_data[1];

  // BRAM commands follow the requests directly; write strobe only on accept.
  assign ADDR_A = REQ_ADDR_0;
  assign DI_A   = REQ_DATA_0;
  assign WE_A   = w_accept[0] & REQ_WE_0;
  assign ADDR_B = REQ_ADDR_1;
  assign DI_B   = REQ_DATA_1;
  assign WE_B   = w_accept[1] & REQ_WE_1;

endmodule

// File: tb/tb_bram_port_arbiter.sv
// -----------------------------------------------------------------------------
// tb_bram_port_arbiter
// Directed bench for bram_port_arbiter with a behavioural dual-port BRAM.
// Memory preloads to 0x10 + address so read data is predictable by hand.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module tb_bram_port_arbiter;

  localparam int unsigned AW = 4;
  localparam int unsigned DW = 8;

  logic          CLK = 1'b0;
  logic          RESET_N;
  logic          REQ_VALID_0, REQ_READY_0, REQ_WE_0;
  logic [AW-1:0] REQ_ADDR_0;
  logic [DW-1:0] REQ_DATA_0;
  logic          RESP_VALID_0, RESP_READY_0;
  logic [DW-1:0] RESP_DATA_0;
  logic          REQ_VALID_1, REQ_READY_1, REQ_WE_1;
  logic [AW-1:0] REQ_ADDR_1;
  logic [DW-1:0] REQ_DATA_1;
  logic          RESP_VALID_1, RESP_READY_1;
  logic [DW-1:0] RESP_DATA_1;
  logic [AW-1:0] ADDR_A, ADDR_B;
  logic [DW-1:0] DI_A, DI_B, DO_A, DO_B;
  logic          WE_A, WE_B;

  int errors = 0;
  int checks = 0;

  always #5 CLK = ~CLK;

  bram_port_arbiter #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) dut (
    .CLK(CLK), .RESET_N(RESET_N),
    .REQ_VALID_0(REQ_VALID_0), .REQ_READY_0(REQ_READY_0), .REQ_WE_0(REQ_WE_0),
    .REQ_ADDR_0(REQ_ADDR_0), .REQ_DATA_0(REQ_DATA_0),
    .RESP_VALID_0(RESP_VALID_0), .RESP_READY_0(RESP_READY_0), .RESP_DATA_0(RESP_DATA_0),
    .REQ_VALID_1(REQ_VALID_1), .REQ_READY_1(REQ_READY_1), .REQ_WE_1(REQ_WE_1),
    .REQ_ADDR_1(REQ_ADDR_1), .REQ_DATA_1(REQ_DATA_1),
    .RESP_VALID_1(RESP_VALID_1), .RESP_READY_1(RESP_READY_1), .RESP_DATA_1(RESP_DATA_1),
    .ADDR_A(ADDR_A), .DI_A(DI_A), .WE_A(WE_A), .DO_A(DO_A),
    .ADDR_B(ADDR_B), .DI_B(DI_B), .WE_B(WE_B), .DO_B(DO_B)
  );

  // Dual-port BRAM model, registered read, preloaded on the first edge.
  logic [DW-1:0] mem [16];
  logic          mem_loaded = 1'b0;

  always @(posedge CLK) begin
    if (!mem_loaded) begin
      for (int i = 0; i < 16; i++) mem[i] <= 8'(8'h10 + i);
      mem_loaded <= 1'b1;
    end else begin
      if (WE_A) mem[ADDR_A] <= DI_A;
      if (WE_B) mem[ADDR_B] <= DI_B;
    end
    DO_A <= mem[ADDR_A];
    DO_B <= mem[ADDR_B];
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge CLK);
    @(negedge CLK);
  endtask

  initial begin
    RESET_N      = 1'b0;
    REQ_VALID_0  = 1'b1; REQ_WE_0 = 1'b1; REQ_ADDR_0 = '0; REQ_DATA_0 = '0;
    REQ_VALID_1  = 1'b0; REQ_WE_1 = 1'b0; REQ_ADDR_1 = '0; REQ_DATA_1 = '0;
    RESP_READY_0 = 1'b1; RESP_READY_1 = 1'b1;

    // Reset state, with a write request pending on client 0.
    @(negedge CLK); #1;
    check("rst_ready0", REQ_READY_0, 1'b0);
    check("rst_we_a", WE_A, 1'b0);
    check("rst_rvalid0", RESP_VALID_0, 1'b0);
    check("rst_rvalid1", RESP_VALID_1, 1'b0);
    step();
    RESET_N = 1'b1;
    REQ_VALID_0 = 1'b0; REQ_WE_0 = 1'b0;

    // Conflict: client 0 writes addr 7, client 1 reads addr 7.
    REQ_VALID_0 = 1'b1; REQ_WE_0 = 1'b1; REQ_ADDR_0 = 4'd7; REQ_DATA_0 = 8'hC3;
    REQ_VALID_1 = 1'b1; REQ_WE_1 = 1'b0; REQ_ADDR_1 = 4'd7;
    #1;
    check("conf_ready0", REQ_READY_0, 1'b1);
    check("conf_ready1", REQ_READY_1, 1'b0);
    check("conf_we_a", WE_A, 1'b1);
    check("conf_we_b", WE_B, 1'b0);
    step();
    REQ_VALID_0 = 1'b0; REQ_WE_0 = 1'b0;
    #1;
    check("conf_ready1_next", REQ_READY_1, 1'b1);
    step();
    REQ_VALID_1 = 1'b0;
    #1;
    check("conf_rvalid1_lat1", RESP_VALID_1, 1'b0);
    step(); #1;
    check("conf_rvalid1_lat2", RESP_VALID_1, 1'b1);
    check("conf_rdata1", RESP_DATA_1, 8'hC3);
    step(); #1;
    check("conf_rvalid1_drained", RESP_VALID_1, 1'b0);

    // Client 0 write 0x5A to addr 3 then read it back.
    REQ_VALID_0 = 1'b1; REQ_WE_0 = 1'b1; REQ_ADDR_0 = 4'd3; REQ_DATA_0 = 8'h5A;
    #1;
    check("wr3_ready0", REQ_READY_0, 1'b1);
    check("wr3_we_a", WE_A, 1'b1);
    step();
    REQ_WE_0 = 1'b0;
    #1;
    check("rd3_ready0", REQ_READY_0, 1'b1);
    check("rd3_we_a", WE_A, 1'b0);
    step();
    REQ_VALID_0 = 1'b0;
    #1;
    check("rd3_rvalid0_t2", RESP_VALID_0, 1'b0);
    step(); #1;
    check("rd3_rvalid0_t3", RESP_VALID_0, 1'b1);
    check("rd3_rdata0", RESP_DATA_0, 8'h5A);
    step(); #1;
    check("rd3_rvalid0_drained", RESP_VALID_0, 1'b0);

    // Reset pulse the cycle after a read is accepted.
    REQ_VALID_0 = 1'b1; REQ_WE_0 = 1'b0; REQ_ADDR_0 = 4'd5;
    #1;
    check("rstmid_ready0", REQ_READY_0, 1'b1);
    step();
    RESET_N = 1'b0;
    #1;
    check("rstmid_ready0_low", REQ_READY_0, 1'b0);
    step();
    REQ_VALID_0 = 1'b0;
    RESET_N = 1'b1;
    #1;
    check("rstmid_rvalid0_a", RESP_VALID_0, 1'b0);
    step(); #1;
    check("rstmid_rvalid0_b", RESP_VALID_0, 1'b0);
    step(); #1;
    check("rstmid_rvalid0_c", RESP_VALID_0, 1'b0);

    // Write-write conflicts on addr 2: grants alternate 0,1,0,1 from reset.
    for (int i = 0; i < 4; i++) begin
      REQ_VALID_0 = 1'b1; REQ_WE_0 = 1'b1; REQ_ADDR_0 = 4'd2; REQ_DATA_0 = 8'(8'hA0 + i);
      REQ_VALID_1 = 1'b1; REQ_WE_1 = 1'b1; REQ_ADDR_1 = 4'd2; REQ_DATA_1 = 8'(8'hB0 + i);
      #1;
      check($sformatf("ww_ready0_%0d", i), REQ_READY_0, (i % 2) == 0);
      check($sformatf("ww_ready1_%0d", i), REQ_READY_1, (i % 2) == 1);
      check($sformatf("ww_we_a_%0d", i), WE_A, (i % 2) == 0);
      check($sformatf("ww_we_b_%0d", i), WE_B, (i % 2) == 1);
      step();
    end
    REQ_VALID_1 = 1'b0; REQ_WE_1 = 1'b0;
    REQ_WE_0 = 1'b0;
    #1;
    check("ww_rd_ready0", REQ_READY_0, 1'b1);
    step();
    REQ_VALID_0 = 1'b0;
    step(); #1;
    check("ww_rd_rvalid0", RESP_VALID_0, 1'b1);
    check("ww_rd_rdata0", RESP_DATA_0, 8'hB3);
    step();

    // Read-read to the same address: no conflict.
    REQ_VALID_0 = 1'b1; REQ_WE_0 = 1'b0; REQ_ADDR_0 = 4'd4;
    REQ_VALID_1 = 1'b1; REQ_WE_1 = 1'b0; REQ_ADDR_1 = 4'd4;
    #1;
    check("rr_ready0", REQ_READY_0, 1'b1);
    check("rr_ready1", REQ_READY_1, 1'b1);
    step();
    REQ_VALID_0 = 1'b0; REQ_VALID_1 = 1'b0;
    step(); #1;
    check("rr_rvalid0", RESP_VALID_0, 1'b1);
    check("rr_rvalid1", RESP_VALID_1, 1'b1);
    check("rr_rdata0", RESP_DATA_0, 8'h14);
    check("rr_rdata1", RESP_DATA_1, 8'h14);
    step();

    // Client 1 back-pressure: two reads accepted, then blocked.
    RESP_READY_1 = 1'b0;
    REQ_VALID_1 = 1'b1; REQ_WE_1 = 1'b0; REQ_ADDR_1 = 4'd8;
    #1;
    check("bp_ready1_first", REQ_READY_1, 1'b1);
    step();
    REQ_ADDR_1 = 4'd9;
    #1;
    check("bp_ready1_second", REQ_READY_1, 1'b1);
    step();
    REQ_ADDR_1 = 4'd10;
    #1;
    check("bp_ready1_full", REQ_READY_1, 1'b0);
    step(); #1;
    check("bp_ready1_still_full", REQ_READY_1, 1'b0);
    check("bp_rvalid1", RESP_VALID_1, 1'b1);
    check("bp_rdata1_head", RESP_DATA_1, 8'h18);
    // A write is not blocked by a full response path.
    REQ_WE_1 = 1'b1; REQ_ADDR_1 = 4'd12; REQ_DATA_1 = 8'h77;
    #1;
    check("bp_wr_ready1", REQ_READY_1, 1'b1);
    check("bp_wr_we_b", WE_B, 1'b1);
    step();
    REQ_WE_1 = 1'b0; REQ_ADDR_1 = 4'd10;
    #1;
    check("bp_ready1_after_wr", REQ_READY_1, 1'b0);
    check("bp_rdata1_stable", RESP_DATA_1, 8'h18);
    RESP_READY_1 = 1'b1;
    #1;
    check("bp_ready1_resume", REQ_READY_1, 1'b1);
    step();
    REQ_VALID_1 = 1'b0;
    #1;
    check("bp_drain_rvalid1_a", RESP_VALID_1, 1'b1);
    check("bp_drain_rdata1_a", RESP_DATA_1, 8'h19);
    step(); #1;
    check("bp_drain_rvalid1_b", RESP_VALID_1, 1'b1);
    check("bp_drain_rdata1_b", RESP_DATA_1, 8'h1A);
    step(); #1;
    check("bp_drain_empty", RESP_VALID_1, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
